// File: rtl/fsk_tx_scheduler_pkg.sv
// Shared defaults and state encoding for the FSK frame scheduler.
package fsk_pkg;

  localparam int unsigned DEF_CW_W        = 14;
  localparam int unsigned DEF_BIT_CYCLES  = 16;
  localparam int unsigned DEF_PRE_LEN     = 8;
  localparam logic [7:0]  DEF_PRE_PATTERN = 8'b01111110;
  localparam int unsigned DEF_GAP_BITS    = 2;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    CHID,
    DATA,
    GAP
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fsk_tx_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter; pointer moves to the loser on an accepted grant.
module fsk_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output logic       o_gnt_chan
);

  logic r_ptr;
  logic w_win;

  always_comb begin
    o_gnt = '0;
    w_win = i_req[r_ptr] ? r_ptr : ~r_ptr;
    if (i_en && (|i_req)) begin
      o_gnt[w_win] = 1'b1;
    end
    o_gnt_chan = w_win;
  end

  // A grant always coincides with the requester's valid, so it is the transfer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= 1'b0;
    end else if (|o_gnt) begin
      r_ptr <= ~w_win;
    end
  end

endmodule

// File: rtl/fsk_tx_scheduler.sv
// Frame scheduler: arbitrates two codeword sources and serialises preamble, channel ID, data and gap.
module fsk_tx_scheduler
  import fsk_pkg::*;
#(
  parameter int unsigned         CW_W        = DEF_CW_W,
  parameter int unsigned         BIT_CYCLES  = DEF_BIT_CYCLES,
  parameter int unsigned         PRE_LEN     = DEF_PRE_LEN,
  parameter logic [PRE_LEN-1:0]  PRE_PATTERN = DEF_PRE_PATTERN,
  parameter int unsigned         GAP_BITS    = DEF_GAP_BITS
) (
  input  logic            clk2,
  input  logic            reset,
  input  logic            en,
  input  logic [CW_W-1:0] cw0,
  input  logic            cw0_valid,
  output logic            cw0_ready,
  input  logic [CW_W-1:0] cw1,
  input  logic            cw1_valid,
  output logic            cw1_ready,
  output logic            tx_bit,
  output logic            tx_active,
  output logic            bit_strobe,
  output logic            tx_chan,
  output logic            frame_done,
  output logic            busy
);

  localparam int unsigned CYC_W = $clog2(BIT_CYCLES);
  localparam int unsigned IDX_W = $clog2(max3(PRE_LEN, CW_W, GAP_BITS));

  state_t             r_state, w_state_nxt;
  logic [CYC_W-1:0]   r_cyc, w_cyc_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [CW_W-1:0]    r_cw;
  logic               r_chan;
  logic               r_tx_bit, r_tx_active, r_bit_strobe;
  logic [1:0]         w_gnt;
  logic               w_gnt_chan;
  logic               w_xfer;
  logic               w_bit_end;
  logic               w_tx_bit_nxt;
  logic [PRE_LEN-1:0] w_pre_sh;
  logic [CW_W-1:0]    w_cw_sh;

  fsk_rr_arb2 u_arb (
    .i_clk      (clk2),
    .i_reset    (reset),
    .i_en       (en && (r_state == IDLE)),
    .i_req      ({cw1_valid, cw0_valid}),
    .o_gnt      (w_gnt),
    .o_gnt_chan (w_gnt_chan)
  );

  assign w_xfer    = |w_gnt;
  assign cw0_ready = w_gnt[0];
  assign cw1_ready = w_gnt[1];
  assign w_bit_end = (r_cyc == CYC_W'(BIT_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cyc_nxt   = '0;
    if (r_state != IDLE) begin
      w_cyc_nxt = w_bit_end ? '0 : r_cyc + 1'b1;
    end
    unique case (r_state)
      IDLE: if (w_xfer) begin
        w_state_nxt = PRE;
        w_idx_nxt   = '0;
      end
      PRE: if (w_bit_end) begin
        if (r_idx == IDX_W'(PRE_LEN - 1)) begin
          w_state_nxt = CHID;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      CHID: if (w_bit_end) begin
        w_state_nxt = DATA;
        w_idx_nxt   = '0;
      end
      DATA: if (w_bit_end) begin
        if (r_idx == IDX_W'(CW_W - 1)) begin
          w_state_nxt = GAP;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      GAP: if (w_bit_end) begin
        if (r_idx == IDX_W'(GAP_BITS - 1)) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the bit they describe.
  always_comb begin
    w_pre_sh     = PRE_PATTERN << w_idx_nxt;
    w_cw_sh      = r_cw >> w_idx_nxt;
    w_tx_bit_nxt = 1'b0;
    unique case (w_state_nxt)
      PRE:     w_tx_bit_nxt = w_pre_sh[PRE_LEN-1];
      CHID:    w_tx_bit_nxt = r_chan;
      DATA:    w_tx_bit_nxt = w_cw_sh[0];
      default: w_tx_bit_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk2) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cyc        <= '0;
      r_idx        <= '0;
      r_cw         <= '0;
      r_chan       <= 1'b0;
      r_tx_bit     <= 1'b0;
      r_tx_active  <= 1'b0;
      r_bit_strobe <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cyc        <= w_cyc_nxt;
      r_idx        <= w_idx_nxt;
      r_tx_bit     <= w_tx_bit_nxt;
      r_tx_active  <= (w_state_nxt == PRE) || (w_state_nxt == CHID) || (w_state_nxt == DATA);
      r_bit_strobe <= (w_state_nxt != IDLE) && (w_cyc_nxt == '0);
      if (w_xfer) begin
        r_cw   <= w_gnt_chan ? cw1 : cw0;
        r_chan <= w_gnt_chan;
      end
    end
  end

  assign tx_bit     = r_tx_bit;
  assign tx_active  = r_tx_active;
  assign bit_strobe = r_bit_strobe;
  assign tx_chan    = r_chan;
  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == DATA) && w_bit_end && (r_idx == IDX_W'(CW_W - 1));

endmodule

// File: tb/tb_fsk_tx_scheduler.sv
// Directed bench for fsk_tx_scheduler at default parameters.
module tb_fsk_tx_scheduler;

  logic        clk2 = 1'b0;
  logic        reset, en;
  logic [13:0] cw0, cw1;
  logic        cw0_valid, cw1_valid;
  logic        cw0_ready, cw1_ready;
  logic        tx_bit, tx_active, bit_strobe, tx_chan, frame_done, busy;

  int checks = 0;
  int errors = 0;

  fsk_tx_scheduler dut (
    .clk2       (clk2),
    .reset      (reset),
    .en         (en),
    .cw0        (cw0),
    .cw0_valid  (cw0_valid),
    .cw0_ready  (cw0_ready),
    .cw1        (cw1),
    .cw1_valid  (cw1_valid),
    .cw1_ready  (cw1_ready),
    .tx_bit     (tx_bit),
    .tx_active  (tx_active),
    .bit_strobe (bit_strobe),
    .tx_chan    (tx_chan),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk2 = ~clk2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in an IDLE cycle whose grant is already visible; follows the whole frame plus gap.
  task automatic run_frame(input logic chan, input logic [13:0] cw,
                           input int drop_en_at, input bit drop_valid);
    logic       exp_bits[25];
    logic [7:0] pre;
    int         k, n, fd_n, fd_cnt;
    bit         done;
    pre = 8'b01111110;
    for (int i = 0; i < 8; i++) exp_bits[i] = pre[7-i];
    exp_bits[8] = chan;
    for (int i = 0; i < 14; i++) exp_bits[9+i] = cw[i];
    exp_bits[23] = 1'b0;
    exp_bits[24] = 1'b0;
    k = 0; n = 0; fd_n = -1; fd_cnt = 0; done = 1'b0;
    while (!done && n < 600) begin
      @(negedge clk2); #1;
      n++;
      if (n == 1) begin
        chk("tx_chan", tx_chan, chan);
        chk("busy_start", busy, 1);
        if (drop_valid) begin
          cw0_valid = 1'b0; cw1_valid = 1'b0;
          cw0 = ~cw0; cw1 = ~cw1;
        end
      end
      if (bit_strobe) begin
        if (k < 25) begin
          chk("strobe_pos", n, 1 + 16*k);
          chk("tx_bit", tx_bit, exp_bits[k]);
          chk("tx_active", tx_active, (k < 23) ? 1 : 0);
        end else begin
          chk("extra_strobe", k, 24);
        end
        if (k == drop_en_at) en = 1'b0;
        k++;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_n = n;
      end
      if (!busy) done = 1'b1;
    end
    chk("frame_done_lat", fd_n, 368);
    chk("frame_done_cnt", fd_cnt, 1);
    chk("strobe_cnt", k, 25);
    chk("frame_end", n, 401);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0;
    cw0 = '0; cw1 = '0; cw0_valid = 1'b0; cw1_valid = 1'b0;
    repeat (3) @(negedge clk2);
    reset = 1'b0;
    #1;
    chk("rst_tx_bit", tx_bit, 0);
    chk("rst_tx_active", tx_active, 0);
    chk("rst_strobe", bit_strobe, 0);
    chk("rst_tx_chan", tx_chan, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", cw0_ready, 0);
    chk("rst_ready1", cw1_ready, 0);

    // Single frame on ch0; inputs scrambled after transfer.
    cw0 = 14'h2A5D; cw0_valid = 1'b1; en = 1'b1;
    #1;
    chk("t1_ready0", cw0_ready, 1);
    chk("t1_ready1", cw1_ready, 0);
    run_frame(1'b0, 14'h2A5D, -1, 1'b1);

    // Reset pointer, then continuous requests on both channels.
    reset = 1'b1;
    @(negedge clk2);
    reset = 1'b0;
    cw0 = 14'h0001; cw1 = 14'h3FFF; cw0_valid = 1'b1; cw1_valid = 1'b1;
    #1;
    chk("t2_g1_ready0", cw0_ready, 1);
    chk("t2_g1_ready1", cw1_ready, 0);
    run_frame(1'b0, 14'h0001, -1, 1'b0);
    chk("t2_g2_ready1", cw1_ready, 1);
    chk("t2_g2_ready0", cw0_ready, 0);
    run_frame(1'b1, 14'h3FFF, -1, 1'b0);
    chk("t2_g3_ready0", cw0_ready, 1);
    chk("t2_g3_ready1", cw1_ready, 0);
    run_frame(1'b0, 14'h0001, -1, 1'b0);
    chk("t2_g4_ready1", cw1_ready, 1);
    chk("t2_g4_ready0", cw0_ready, 0);
    run_frame(1'b1, 14'h3FFF, -1, 1'b0);
    cw0_valid = 1'b0; cw1_valid = 1'b0;
    #1;
    chk("t2_drop_ready0", cw0_ready, 0);
    chk("t2_drop_ready1", cw1_ready, 0);

    // Pointer favours ch0 but only ch1 requests.
    @(negedge clk2); #1;
    cw1 = 14'h1234; cw1_valid = 1'b1;
    #1;
    chk("t3_ready1", cw1_ready, 1);
    chk("t3_ready0", cw0_ready, 0);
    run_frame(1'b1, 14'h1234, -1, 1'b1);

    // en dropped at DATA bit 5 (strobe 14).
    cw0 = 14'h1555; cw0_valid = 1'b1;
    #1;
    chk("t4_ready0", cw0_ready, 1);
    run_frame(1'b0, 14'h1555, 14, 1'b0);
    chk("t4_hold_ready0", cw0_ready, 0);
    chk("t4_hold_ready1", cw1_ready, 0);
    repeat (5) @(negedge clk2);
    #1;
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_ready0", cw0_ready, 0);
    en = 1'b1;
    #1;
    chk("t4_reen_ready0", cw0_ready, 1);
    run_frame(1'b0, 14'h1555, -1, 1'b1);

    // Reset during PRE bit 3 of a ch1 frame.
    cw1 = 14'h2C3A; cw1_valid = 1'b1;
    #1;
    chk("t5_ready1", cw1_ready, 1);
    repeat (50) @(negedge clk2);
    #1;
    chk("t5_mid_active", tx_active, 1);
    chk("t5_mid_chan", tx_chan, 1);
    reset = 1'b1; cw1_valid = 1'b0;
    @(negedge clk2); #1;
    chk("t5_tx_bit", tx_bit, 0);
    chk("t5_tx_active", tx_active, 0);
    chk("t5_strobe", bit_strobe, 0);
    chk("t5_tx_chan", tx_chan, 0);
    chk("t5_frame_done", frame_done, 0);
    chk("t5_busy", busy, 0);
    reset = 1'b0;
    cw1_valid = 1'b1;
    #1;
    chk("t5_restart_ready1", cw1_ready, 1);
    run_frame(1'b1, 14'h2C3A, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
